// File: rtl/attack_pkg.sv
// attack_pkg: shared states, limits and saturating-step helper for attack_sequencer.
package attack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        LAUNCH,
        FLIGHT,
        SCORE,
        DONE,
        WAIT_TURN
    } state_e;

    localparam logic [6:0] ANGLE_MIN  = 7'd0;
    localparam logic [6:0] ANGLE_MAX  = 7'd90;
    localparam logic [6:0] POWER_MIN  = 7'd10;
    localparam logic [6:0] POWER_MAX  = 7'd100;
    localparam logic [6:0] ANGLE_INIT = 7'd45;
    localparam logic [6:0] POWER_INIT = 7'd50;
    localparam logic [9:0] DIST_MISS  = 10'd1023;

    function automatic logic [6:0] sat_step(
        input logic [6:0] v,
        input logic       inc,
        input logic       dec,
        input logic [6:0] lo,
        input logic [6:0] hi
    );
        if (inc && v < hi) return v + 7'd1;
        if (dec && v > lo) return v - 7'd1;
        return v;
    endfunction

endpackage

// File: rtl/attack_sequencer_key_repeat.sv
// key_repeat: step pulse on the press frame, then every REPEAT_FRAMES frames while held.
module key_repeat #(
    parameter int REPEAT_FRAMES = 4
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic key_i,
    input  logic en_i,
    output logic step_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (en_i && key_i) ? ((cnt_q == 8'(REPEAT_FRAMES - 1)) ? 8'd0 : cnt_q + 8'd1) : 8'd0;
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign step_o = en_i && key_i && cnt_q == 8'd0;

endmodule

// File: rtl/attack_sequencer.sv
// attack_sequencer: per-turn aim/launch/score controller between keys, projectile and game_state.
// Define ATTACK_TURN_TIMER_EN to auto-fire after TURN_FRAMES frames of aiming.
module attack_sequencer
    import attack_pkg::*;
#(
    parameter logic [8:0] MAX_HARM       = 9'd40,
    parameter int         REPEAT_FRAMES  = 4,
    parameter int         FLIGHT_TIMEOUT = 255,
    parameter int         TURN_FRAMES    = 600
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [1:0] game_turn,
    input  logic       aim_up,
    input  logic       aim_down,
    input  logic       power_up,
    input  logic       power_down,
    input  logic       fire,
    input  logic       proj_done,
    input  logic [9:0] hit_dist,
    output logic [6:0] angle,
    output logic [6:0] power,
    output logic       launch,
    output logic [8:0] harm_by_1,
    output logic [8:0] harm_by_2,
    output logic       end_set_1,
    output logic       end_set_2,
    output logic       aiming
);

    state_e      state_q, state_d;
    logic        player_q, player_d;
    logic [6:0]  angle_q, angle_d, power_q, power_d;
    logic [6:0]  st_angle_q [2];
    logic [6:0]  st_angle_d [2];
    logic [6:0]  st_power_q [2];
    logic [6:0]  st_power_d [2];
    logic        armed_q, armed_d;
    logic [15:0] flight_q, flight_d;
    logic [9:0]  dist_q, dist_d;
    logic [8:0]  harm1_q, harm1_d, harm2_q, harm2_d, harm_v;
    logic        launch_q, end1_q, end2_q, aiming_q;
    logic        up_s, dn_s, pu_s, pd_s, aim_en, fire_go, abort;

    assign aim_en = state_q == AIM;

    key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_aim_up (
        .frame_clk(frame_clk), .Reset(Reset), .key_i(aim_up), .en_i(aim_en), .step_o(up_s)
    );
    key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_aim_dn (
        .frame_clk(frame_clk), .Reset(Reset), .key_i(aim_down), .en_i(aim_en), .step_o(dn_s)
    );
    key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_pow_up (
        .frame_clk(frame_clk), .Reset(Reset), .key_i(power_up), .en_i(aim_en), .step_o(pu_s)
    );
    key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_pow_dn (
        .frame_clk(frame_clk), .Reset(Reset), .key_i(power_down), .en_i(aim_en), .step_o(pd_s)
    );

`ifdef ATTACK_TURN_TIMER_EN
    logic [15:0] aim_cnt_q, aim_cnt_d;

    // Held at zero outside AIM, so it restarts on every AIM entry.
    always_comb begin
        aim_cnt_d = aim_en ? aim_cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) aim_cnt_q <= 16'd0;
        else        aim_cnt_q <= aim_cnt_d;
    end

    assign fire_go = (armed_q && fire) || aim_cnt_q == 16'(TURN_FRAMES);
`else
    logic unused_turn_frames;
    assign unused_turn_frames = ^TURN_FRAMES;
    assign fire_go = armed_q && fire;
`endif

    // dist_q < MAX_HARM < 512 whenever the difference is taken, so 9 bits hold it exactly.
    assign harm_v = (dist_q < 10'(MAX_HARM)) ? MAX_HARM - dist_q[8:0] : 9'd0;
    assign abort  = state_q != IDLE && game_turn == 2'b00;

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        angle_d    = angle_q;
        power_d    = power_q;
        st_angle_d = st_angle_q;
        st_power_d = st_power_q;
        armed_d    = armed_q;
        flight_d   = flight_q;
        dist_d     = dist_q;
        harm1_d    = harm1_q;
        harm2_d    = harm2_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (^game_turn) begin
                    player_d = game_turn[1];
                    angle_d  = st_angle_q[game_turn[1]];
                    power_d  = st_power_q[game_turn[1]];
                    armed_d  = 1'b0;
                    state_d  = AIM;
                end
                AIM: begin
                    angle_d = sat_step(angle_q, up_s && !aim_down, dn_s && !aim_up, ANGLE_MIN, ANGLE_MAX);
                    power_d = sat_step(power_q, pu_s && !power_down, pd_s && !power_up, POWER_MIN, POWER_MAX);
                    armed_d = armed_q || !fire;
                    if (fire_go) begin
                        st_angle_d[player_q] = angle_d;
                        st_power_d[player_q] = power_d;
                        state_d              = LAUNCH;
                    end
                end
                LAUNCH: begin
                    flight_d = 16'd0;
                    state_d  = FLIGHT;
                end
                FLIGHT: begin
                    if (proj_done) begin
                        dist_d  = hit_dist;
                        state_d = SCORE;
                    end else if (flight_q == 16'(FLIGHT_TIMEOUT)) begin
                        dist_d  = DIST_MISS;
                        state_d = SCORE;
                    end else begin
                        flight_d = flight_q + 16'd1;
                    end
                end
                SCORE: begin
                    harm1_d = player_q ? harm1_q : harm_v;
                    harm2_d = player_q ? harm_v : harm2_q;
                    state_d = DONE;
                end
                DONE:      state_d = WAIT_TURN;
                WAIT_TURN: state_d = (game_turn != {player_q, !player_q}) ? IDLE : WAIT_TURN;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            player_q   <= 1'b0;
            angle_q    <= ANGLE_INIT;
            power_q    <= POWER_INIT;
            st_angle_q <= '{ANGLE_INIT, ANGLE_INIT};
            st_power_q <= '{POWER_INIT, POWER_INIT};
            armed_q    <= 1'b0;
            flight_q   <= 16'd0;
            dist_q     <= 10'd0;
            harm1_q    <= 9'd0;
            harm2_q    <= 9'd0;
            launch_q   <= 1'b0;
            end1_q     <= 1'b0;
            end2_q     <= 1'b0;
            aiming_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            player_q   <= player_d;
            angle_q    <= angle_d;
            power_q    <= power_d;
            st_angle_q <= st_angle_d;
            st_power_q <= st_power_d;
            armed_q    <= armed_d;
            flight_q   <= flight_d;
            dist_q     <= dist_d;
            harm1_q    <= harm1_d;
            harm2_q    <= harm2_d;
            launch_q   <= state_d == LAUNCH;
            end1_q     <= state_d == DONE && !player_d;
            end2_q     <= state_d == DONE && player_d;
            aiming_q   <= state_d == AIM;
        end
    end

    assign angle     = angle_q;
    assign power     = power_q;
    assign launch    = launch_q;
    assign harm_by_1 = harm1_q;
    assign harm_by_2 = harm2_q;
    assign end_set_1 = end1_q;
    assign end_set_2 = end2_q;
    assign aiming    = aiming_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// tb_attack_sequencer: directed turns against a frame-level behavioural model of attack_sequencer.
module tb_attack_sequencer;

    localparam int R  = 4;
    localparam int FT = 255;
    localparam int TF = 600;
    localparam int MH = 40;

    localparam int M_IDLE = 0, M_AIM = 1, M_LAUNCH = 2, M_FLIGHT = 3, M_SCORE = 4, M_DONE = 5, M_WAIT = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] game_turn;
    logic       aim_up, aim_down, power_up, power_down, fire, proj_done;
    logic [9:0] hit_dist;
    logic [6:0] angle, power;
    logic       launch, end_set_1, end_set_2, aiming;
    logic [8:0] harm_by_1, harm_by_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    attack_sequencer #(
        .MAX_HARM(9'd40), .REPEAT_FRAMES(R), .FLIGHT_TIMEOUT(FT), .TURN_FRAMES(TF)
    ) dut (
        .frame_clk(clk), .Reset(rst_n), .game_turn(game_turn),
        .aim_up(aim_up), .aim_down(aim_down), .power_up(power_up), .power_down(power_down),
        .fire(fire), .proj_done(proj_done), .hit_dist(hit_dist),
        .angle(angle), .power(power), .launch(launch),
        .harm_by_1(harm_by_1), .harm_by_2(harm_by_2),
        .end_set_1(end_set_1), .end_set_2(end_set_2), .aiming(aiming)
    );

    // Frame-level model of the turn: phase, per-player stores, held-key frame counts.
    int ph, pl, fl, md, hu, hd, pu, pd, aimt;
    int sa [2];
    int sp [2];
    int ma, mp, h1, h2;
    bit seen, el, e1, e2, eaim;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mvalid = 1'b1;
            ph = M_IDLE; pl = 0; fl = 0; md = 0; aimt = 0; seen = 1'b0;
            hu = 0; hd = 0; pu = 0; pd = 0;
            sa = '{45, 45}; sp = '{50, 50};
            ma = 45; mp = 50; h1 = 0; h2 = 0;
            el = 1'b0; e1 = 1'b0; e2 = 1'b0; eaim = 1'b0;
        end else if (mvalid) begin : step
            int np;
            bit su, sd, spu, spd, go;
            np  = ph;
            su  = aim_up && (hu % R == 0);
            sd  = aim_down && (hd % R == 0);
            spu = power_up && (pu % R == 0);
            spd = power_down && (pd % R == 0);
            if (ph != M_IDLE && game_turn == 2'b00) begin
                np = M_IDLE;
            end else begin
                case (ph)
                    M_IDLE: if (game_turn == 2'b01 || game_turn == 2'b10) begin
                        pl = int'(game_turn) - 1;
                        ma = sa[pl]; mp = sp[pl];
                        seen = 1'b0; aimt = 0;
                        np = M_AIM;
                    end
                    M_AIM: begin
                        if (su && !aim_down) ma = (ma < 90) ? ma + 1 : ma;
                        else if (sd && !aim_up) ma = (ma > 0) ? ma - 1 : ma;
                        if (spu && !power_down) mp = (mp < 100) ? mp + 1 : mp;
                        else if (spd && !power_up) mp = (mp > 10) ? mp - 1 : mp;
                        go = fire && seen;
`ifdef ATTACK_TURN_TIMER_EN
                        go = go || aimt == TF;
`endif
                        seen = seen || !fire;
                        if (go) begin
                            sa[pl] = ma; sp[pl] = mp;
                            np = M_LAUNCH;
                        end
                    end
                    M_LAUNCH: begin fl = 0; np = M_FLIGHT; end
                    M_FLIGHT: begin
                        if (proj_done) begin md = int'(hit_dist); np = M_SCORE; end
                        else if (fl == FT) begin md = 1023; np = M_SCORE; end
                        else fl++;
                    end
                    M_SCORE: begin
                        if (pl == 1) h2 = (md < MH) ? MH - md : 0;
                        else         h1 = (md < MH) ? MH - md : 0;
                        np = M_DONE;
                    end
                    M_DONE: np = M_WAIT;
                    M_WAIT: if (int'(game_turn) != pl + 1) np = M_IDLE;
                    default: np = M_IDLE;
                endcase
            end
            if (ph == M_AIM) begin
                hu = aim_up ? hu + 1 : 0;
                hd = aim_down ? hd + 1 : 0;
                pu = power_up ? pu + 1 : 0;
                pd = power_down ? pd + 1 : 0;
                aimt++;
            end else begin
                hu = 0; hd = 0; pu = 0; pd = 0;
            end
            ph   = np;
            el   = np == M_LAUNCH;
            e1   = np == M_DONE && pl == 0;
            e2   = np == M_DONE && pl == 1;
            eaim = np == M_AIM;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (angle !== 7'(ma) || power !== 7'(mp) || launch !== el || aiming !== eaim ||
                harm_by_1 !== 9'(h1) || harm_by_2 !== 9'(h2) || end_set_1 !== e1 || end_set_2 !== e2) begin
                errors++;
                $display("FAIL model @%0t: angle %0d/%0d power %0d/%0d launch %b/%b aiming %b/%b harm1 %0d/%0d harm2 %0d/%0d end1 %b/%b end2 %b/%b (got/expected)",
                         $time, angle, ma, power, mp, launch, el, aiming, eaim,
                         harm_by_1, h1, harm_by_2, h2, end_set_1, e1, end_set_2, e2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shot(input logic [9:0] d);
        tick();
        fire = 1'b1; tick();
        fire = 1'b0; repeat (3) tick();
        proj_done = 1'b1; hit_dist = d; tick();
        proj_done = 1'b0; tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; game_turn = 2'b00; aim_up = 1'b0; aim_down = 1'b0;
        power_up = 1'b0; power_down = 1'b0; fire = 1'b0; proj_done = 1'b0; hit_dist = 10'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_angle", angle, 45);
        check("reset_power", power, 50);
        check("reset_harm", {harm_by_1, harm_by_2}, 0);
        check("reset_pulses", {launch, end_set_1, end_set_2, aiming}, 0);

        game_turn = 2'b01; tick();
        check("aim_entry", aiming, 1);
        aim_up = 1'b1; repeat (9) tick(); aim_up = 1'b0;
        check("angle_repeat", angle, 48);
        power_down = 1'b1; repeat (2) tick(); power_down = 1'b0;
        check("power_down_once", power, 49);
        power_up = 1'b1; power_down = 1'b1; repeat (5) tick(); power_up = 1'b0; power_down = 1'b0;
        check("power_both_keys", power, 49);

        tick();
        fire = 1'b1; tick();
        check("p1_launch", launch, 1);
        fire = 1'b0; tick();
        check("p1_launch_one_cycle", launch, 0);
        repeat (5) tick();
        proj_done = 1'b1; hit_dist = 10'd15; tick();
        proj_done = 1'b0; tick();
        check("p1_end_set", end_set_1, 1);
        check("p1_harm15", harm_by_1, 25);
        check("p1_harm2_hold", harm_by_2, 0);
        game_turn = 2'b10; fire = 1'b1; tick();
        check("p1_end_set_single", end_set_1, 0);
        repeat (2) tick();
        check("p2_angle", angle, 45);
        check("p2_power", power, 50);
        check("p1_harm_held", harm_by_1, 25);

        proj_done = 1'b1; hit_dist = 10'd0; tick();
        proj_done = 1'b0; repeat (3) tick();
        check("held_fire_no_launch", launch, 0);
        check("stray_done_ignored", harm_by_2, 0);
        fire = 1'b0; tick();
        fire = 1'b1; tick();
        check("p2_launch", launch, 1);
        fire = 1'b0;
        n = 0;
        while (!end_set_2 && n < 300) begin tick(); n++; end
        check("timeout_end_set_2", end_set_2, 1);
        check("timeout_harm", harm_by_2, 0);

        game_turn = 2'b01; repeat (3) tick();
        check("p1_store_angle", angle, 48);
        check("p1_store_power", power, 49);
        aim_up = 1'b1; power_down = 1'b1; repeat (200) tick(); aim_up = 1'b0; power_down = 1'b0;
        check("angle_sat", angle, 90);
        check("power_sat", power, 10);
        shot(10'd40);
        check("p1_end_set_2nd", end_set_1, 1);
        check("harm_dist40", harm_by_1, 0);

        game_turn = 2'b10; repeat (3) tick();
        check("p2_angle_again", angle, 45);
        shot(10'd0);
        check("p2_end_set_hit", end_set_2, 1);
        check("direct_hit", harm_by_2, 40);
        check("p1_harm_untouched", harm_by_1, 0);

        game_turn = 2'b01; repeat (3) tick();
        check("p1_angle90_back", angle, 90);
        check("p1_power10_back", power, 10);
        tick();
        fire = 1'b1; tick();
        fire = 1'b0; repeat (3) tick();
        game_turn = 2'b00; tick();
        check("abort_aiming", aiming, 0);
        proj_done = 1'b1; hit_dist = 10'd2; tick();
        proj_done = 1'b0; repeat (3) tick();
        check("abort_harm1", harm_by_1, 0);
        check("abort_harm2", harm_by_2, 40);

        game_turn = 2'b01; tick();
        aim_down = 1'b1; repeat (3) tick();
        check("aim_down", angle, 89);
        rst_n = 1'b0; tick();
        rst_n = 1'b1; aim_down = 1'b0; game_turn = 2'b00;
        check("midaim_reset_angle", angle, 45);
        check("midaim_reset_power", power, 50);
        check("midaim_reset_harm", {harm_by_1, harm_by_2}, 0);
        check("midaim_reset_aiming", aiming, 0);
        tick();

`ifdef ATTACK_TURN_TIMER_EN
        game_turn = 2'b01; tick();
        n = 0;
        while (!launch && n < 700) begin tick(); n++; end
        check("turn_timer_launch", n, 601);
        game_turn = 2'b00; repeat (2) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
